port_bus_master: RTL

PORT_BUS_MASTER -- requirements
Module: port_bus_master

---
 rtl/port_bus_master.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/port_bus_master.sv
// -----------------------------------------------------------------------------
// port_bus_master
//
// Queues port-bus commands from a valid/ready request interface and replays
// them onto a PicoBlaze-style port bus (port_id / out_port / in_port with
// write_strobe and read_strobe). Read data is returned on a one-cycle rsp_valid
// pulse. A level interrupt from the peripheral is acknowledged between
// transactions, never in the middle of one.
//
// Parameters
//   FIFO_DEPTH  command FIFO entries (power of two, >= 2)
//   RD_LATENCY  cycles from port_id presentation to the in_port sample (>= 1)
//
// Ports
//   sysclk, sysreset        clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_write selects write/read,
//   cmd_port, cmd_data      target port and write data
//   rsp_valid, rsp_port,    read completion pulse with port and data; port and
//   rsp_data                data hold until the next read completes
//   port_id, out_port,      port bus address, write data, read data
//   in_port
//   write_strobe,           one-cycle bus qualifiers (k_write_strobe is unused
//   read_strobe,            and tied low)
//   k_write_strobe
//   interrupt, irq_en       peripheral interrupt level and servicing enable
//   interrupt_ack,          one-cycle acknowledge and coincident event pulse
//   irq_event
//   busy                    a transaction or queued command is outstanding
// -----------------------------------------------------------------------------
module port_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_port,
    output logic [7:0] rsp_data,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    input  logic [7:0] in_port,
    output logic       write_strobe,
    output logic       k_write_strobe,
    output logic       read_strobe,
    input  logic       interrupt,
    output logic       interrupt_ack,
    input  logic       irq_en,
    output logic       irq_event,
    output logic       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    // RDWAIT counts down from RD_LATENCY-2 to 0, giving RD_LATENCY-1 cycles.
    localparam logic [CW-1:0] WAIT_INIT = CW'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam bit            RD_SKIP   = (RD_LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    // ---------------------------------------------------------------- state
    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          cur_write_q, cur_write_d;
    logic          rsp_pend_q, rsp_pend_d;
    logic [7:0]    rd_cap_q, rd_cap_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;

    logic [7:0]    port_id_q, port_id_d;
    logic [7:0]    out_port_q, out_port_d;
    logic          write_strobe_q, write_strobe_d;
    logic          read_strobe_q, read_strobe_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_port_q, rsp_port_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          interrupt_ack_q, interrupt_ack_d;
    logic          irq_event_q, irq_event_d;
    logic          busy_q, busy_d;

    // Entry layout: {write, port[7:0], data[7:0]}
    logic [16:0]   fifo_mem [FIFO_DEPTH];
    logic [16:0]   head;
    logic          push, pop, fifo_empty, irq_take, rd_done;

    assign push       = cmd_valid && cmd_ready_q;
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem[rd_ptr_q];
    assign irq_take   = interrupt && irq_en;
    assign pop        = (state_q == S_IDLE) && (state_d == S_ISSUE);

    // The cycle whose closing edge samples in_port.
    assign rd_done = (state_q == S_ISSUE && !cur_write_q && RD_SKIP) ||
                     (state_q == S_RDWAIT && wait_cnt_q == '0);

    // ------------------------------------------------------ storage array
    always_ff @(posedge sysclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_write, cmd_port, cmd_data};
        end
    end

    // --------------------------------------------------------- registers
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q         <= S_IDLE;
            wait_cnt_q      <= '0;
            cur_write_q     <= 1'b0;
            rsp_pend_q      <= 1'b0;
            rd_cap_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            cmd_ready_q     <= 1'b1;
            port_id_q       <= '0;
            out_port_q      <= '0;
            write_strobe_q  <= 1'b0;
            read_strobe_q   <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_port_q      <= '0;
            rsp_data_q      <= '0;
            interrupt_ack_q <= 1'b0;
            irq_event_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            cur_write_q     <= cur_write_d;
            rsp_pend_q      <= rsp_pend_d;
            rd_cap_q        <= rd_cap_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            cmd_ready_q     <= cmd_ready_d;
            port_id_q       <= port_id_d;
            out_port_q      <= out_port_d;
            write_strobe_q  <= write_strobe_d;
            read_strobe_q   <= read_strobe_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_port_q      <= rsp_port_d;
            rsp_data_q      <= rsp_data_d;
            interrupt_ack_q <= interrupt_ack_d;
            irq_event_q     <= irq_event_d;
            busy_q          <= busy_d;
        end
    end

    // ------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // While a captured read is being returned the FSM waits one
                // cycle, so the response always precedes a following ack or
                // issue.
                if (!rsp_pend_q) begin
                    if (irq_take) begin
                        state_d = S_ACK;
                    end else if (!fifo_empty) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cur_write_q || RD_SKIP) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ FIFO pointers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d != FULL_CNT);
    end

    // ------------------------------------------------------ outputs
    always_comb begin
        cur_write_d     = cur_write_q;
        wait_cnt_d      = wait_cnt_q;
        rsp_pend_d      = rsp_pend_q;
        rd_cap_d        = rd_cap_q;
        port_id_d       = port_id_q;
        out_port_d      = out_port_q;
        write_strobe_d  = 1'b0;
        read_strobe_d   = 1'b0;
        rsp_valid_d     = 1'b0;
        rsp_port_d      = rsp_port_q;
        rsp_data_d      = rsp_data_q;

        if (pop) begin
            cur_write_d = head[16];
            port_id_d   = head[15:8];
            if (head[16]) begin
                out_port_d     = head[7:0];
                write_strobe_d = 1'b1;
            end else begin
                read_strobe_d  = 1'b1;
            end
        end

        if (state_q == S_ISSUE) begin
            wait_cnt_d = WAIT_INIT;
        end else if (state_q == S_RDWAIT && wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - CW'(1);
        end

        if (rd_done) begin
            rd_cap_d   = in_port;
            rsp_pend_d = 1'b1;
        end

        if (rsp_pend_q) begin
            rsp_pend_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_port_d  = port_id_q;
            rsp_data_d  = rd_cap_q;
        end

        interrupt_ack_d = (state_d == S_ACK);
        irq_event_d     = (state_d == S_ACK);
        busy_d          = (state_d != S_IDLE) || (count_d != '0) || rsp_pend_d;
    end

    assign cmd_ready      = cmd_ready_q;
    assign port_id        = port_id_q;
    assign out_port       = out_port_q;
    assign write_strobe   = write_strobe_q;
    assign read_strobe    = read_strobe_q;
    assign k_write_strobe = 1'b0;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_port       = rsp_port_q;
    assign rsp_data       = rsp_data_q;
    assign interrupt_ack  = interrupt_ack_q;
    assign irq_event      = irq_event_q;
    assign busy           = busy_q;

endmodule
